// File: rtl/frame_counter_pkg.sv
// Purpose: shared default constants for the frame-rate divider.
// Latency: n/a (constants only).
// Backpressure: n/a.
package frame_counter_pkg;

  localparam int FRAME_DIV_DEFAULT = 2;   // frames per frame_enable strobe
  localparam int DIV_W_DEFAULT     = 8;   // width of the divide counter
  localparam int CNT_W_DEFAULT     = 16;  // width of the running frame index

endpackage : frame_counter_pkg

// File: rtl/vsync_edge_detect.sv
// Purpose: polarity-normalise camera vsync, optionally synchronise it, and emit a registered one-cycle frame_start pulse.
// Latency: frame_start high one cycle after the active level is first sampled (+2 cycles with FRAME_COUNTER_SYNC_EN).
// Backpressure: none; every qualifying edge produces a pulse.
//
// Ports: clk (system clock), reset (sync, active-low), vsync_in (raw camera vsync),
//        frame_start (one-cycle pulse per frame start).
// Build option: define FRAME_COUNTER_SYNC_EN to add a two-flop synchroniser for an asynchronous camera.
module vsync_edge_detect
  import frame_counter_pkg::*;
#(
  parameter int VSYNC_ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync_in,
  output logic frame_start
);

  logic vs_raw;
  logic vs;
  logic vs_prev;

  // Normalise so that logic 1 always means "vsync active".
  assign vs_raw = (VSYNC_ACTIVE_LOW != 0) ? ~vsync_in : vsync_in;

`ifdef FRAME_COUNTER_SYNC_EN
  logic [1:0] sync_q;

  // Synchroniser resets to the active level so a vsync already active at
  // reset release does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], vs_raw};
    end
  end

  assign vs = sync_q[1];
`else
  assign vs = vs_raw;
`endif

  // vs_prev also resets active: the first counted frame needs an inactive
  // sample followed by an active one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_prev     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vs_prev     <= vs;
      frame_start <= vs & ~vs_prev;
    end
  end

endmodule : vsync_edge_detect

// File: rtl/frame_counter.sv
// Purpose: frame-rate divider; one-cycle frame_enable every FRAME_DIV-th camera frame start plus a running frame index.
// Latency: frame_enable high 2 cycles after vsync active level is first sampled (4 cycles with FRAME_COUNTER_SYNC_EN).
// Backpressure: none; strobe is fire-and-forget and no frame start is ever dropped.
//
// Ports: clk (system clock), reset (sync, active-low), vsync_in (raw camera vsync),
//        frame_enable (registered one-cycle strobe), frame_count (registered count of all frame starts, wraps).
// Build option: define FRAME_COUNTER_SYNC_EN to synchronise vsync_in before edge detection.
module frame_counter
  import frame_counter_pkg::*;
#(
  parameter int FRAME_DIV        = FRAME_DIV_DEFAULT,
  parameter int DIV_W            = DIV_W_DEFAULT,
  parameter int CNT_W            = CNT_W_DEFAULT,
  parameter int VSYNC_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_in,
  output logic             frame_enable,
  output logic [CNT_W-1:0] frame_count
);

  // A divisor of zero or one that does not fit the counter can never
  // produce a well-defined strobe, so refuse to build it.
  if (FRAME_DIV < 1 || FRAME_DIV > (2 ** DIV_W) - 1) begin : g_bad_frame_div
    $error("frame_counter: FRAME_DIV=%0d out of range for DIV_W=%0d", FRAME_DIV, DIV_W);
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic             frame_start;
  logic [DIV_W-1:0] div_cnt;

  vsync_edge_detect #(
    .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
  ) u_edge (
    .clk         (clk),
    .reset       (reset),
    .vsync_in    (vsync_in),
    .frame_start (frame_start)
  );

  // frame_enable defaults low every cycle so it can only ever be a single
  // cycle wide; frame_count moves on the same edge that raises the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt      <= '0;
      frame_count  <= '0;
      frame_enable <= 1'b0;
    end else begin
      frame_enable <= 1'b0;
      if (frame_start) begin
        frame_count <= frame_count + CNT_W'(1);
        if (div_cnt == DIV_LAST) begin
          div_cnt      <= '0;
          frame_enable <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule : frame_counter

// File: tb/tb_frame_counter.sv
// Purpose: scoreboard bench for frame_counter across four parameterisations.
// Latency: expected strobe cycle is pushed with each stimulus pulse and checked by the monitor.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_frame_counter;

`ifdef FRAME_COUNTER_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [4];
  logic        vs  [4];
  logic        fe  [4];
  logic [15:0] fc0, fc1, fc2;
  logic [3:0]  fc3;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: div 2, 1: div 1 active-low, 2: div 3, 3: div 2 with 4-bit count
  frame_counter #(.FRAME_DIV(2), .DIV_W(8), .CNT_W(16), .VSYNC_ACTIVE_LOW(0)) d0 (
    .clk(clk), .reset(rst[0]), .vsync_in(vs[0]), .frame_enable(fe[0]), .frame_count(fc0));
  frame_counter #(.FRAME_DIV(1), .DIV_W(8), .CNT_W(16), .VSYNC_ACTIVE_LOW(1)) d1 (
    .clk(clk), .reset(rst[1]), .vsync_in(vs[1]), .frame_enable(fe[1]), .frame_count(fc1));
  frame_counter #(.FRAME_DIV(3), .DIV_W(8), .CNT_W(16), .VSYNC_ACTIVE_LOW(0)) d2 (
    .clk(clk), .reset(rst[2]), .vsync_in(vs[2]), .frame_enable(fe[2]), .frame_count(fc2));
  frame_counter #(.FRAME_DIV(2), .DIV_W(8), .CNT_W(4), .VSYNC_ACTIVE_LOW(0)) d3 (
    .clk(clk), .reset(rst[3]), .vsync_in(vs[3]), .frame_enable(fe[3]), .frame_count(fc3));

  function automatic int get_fc(input int i);
    case (i)
      0:       return int'(fc0);
      1:       return int'(fc1);
      2:       return int'(fc2);
      default: return int'(fc3);
    endcase
  endfunction

  function automatic logic act_lvl(input int i);
    return (i == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  // One vsync pulse on DUT id: active for hi cycles, inactive for lo cycles.
  // Caller is positioned at a negedge.
  task automatic pulse(input int id, input int hi, input int lo,
                       input bit strobe, input int cnt);
    exp_t e;
    vs[id] = act_lvl(id);
    if (strobe) begin
      e.id  = id;
      e.cnt = cnt;
      e.cyc = cyc + 2 + EXTRA;
      q.push_back(e);
    end
    repeat (hi) @(negedge clk);
    vs[id] = ~act_lvl(id);
    repeat (lo) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fe[i] === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe_dut", i, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("strobe_dut", i, e.id);
          chk("strobe_count", get_fc(i), e.cnt);
          chk("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0;
      vs[i]  = ~act_lvl(i);
    end

    // Reset held with vsync toggling every half period, off the clock edges.
    @(negedge clk);
    fork
      begin
        #2.5;
        repeat (40) begin
          for (int i = 0; i < 4; i++) vs[i] = ~vs[i];
          #5;
        end
      end
      begin
        repeat (20) begin
          @(negedge clk);
          chk("rst_held_fe0", int'(fe[0]), 0);
          chk("rst_held_fc0", get_fc(0), 0);
          chk("rst_held_fe1", int'(fe[1]), 0);
          chk("rst_held_fc3", get_fc(3), 0);
        end
      end
    join
    @(negedge clk);
    for (int i = 0; i < 4; i++) vs[i] = ~act_lvl(i);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_fc0", get_fc(0), 0);

    // Divide by 2: strobes on frames 2, 4, 6.
    pulse(0, 4, 4, 0, 0);
    pulse(0, 4, 4, 1, 2);
    pulse(0, 4, 4, 0, 0);
    pulse(0, 4, 4, 1, 4);
    pulse(0, 4, 4, 0, 0);
    pulse(0, 4, 4, 1, 6);
    repeat (4) @(negedge clk);
    chk("div2_fc_final", get_fc(0), 6);

    // Divide by 1, active-low: each falling edge strobes, rising edges do nothing.
    pulse(1, 4, 4, 1, 1);
    pulse(1, 4, 4, 1, 2);
    pulse(1, 4, 4, 1, 3);
    repeat (4) @(negedge clk);
    chk("div1_fc_final", get_fc(1), 3);

    // vsync active across reset release: not counted until a fresh edge.
    rst[0] = 1'b0;
    vs[0]  = 1'b1;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("act_release_fc", get_fc(0), 0);
    vs[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("act_release_fc_low", get_fc(0), 0);
    pulse(0, 4, 4, 0, 0);
    chk("act_release_frame1", get_fc(0), 1);
    pulse(0, 4, 4, 1, 2);
    chk("act_release_frame2", get_fc(0), 2);

    // Divide by 3, reset pulsed after two frames discards the partial count.
    pulse(2, 4, 4, 0, 0);
    pulse(2, 4, 4, 0, 0);
    chk("mid_pre_reset_fc", get_fc(2), 2);
    rst[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    chk("mid_reset_fc", get_fc(2), 0);
    @(negedge clk);
    pulse(2, 4, 4, 0, 0);
    pulse(2, 4, 4, 0, 0);
    pulse(2, 4, 4, 1, 3);
    repeat (4) @(negedge clk);
    chk("mid_fc_final", get_fc(2), 3);

    // 4-bit frame_count wraps: 17 frames -> 1; frame 16 strobes with count 0.
    for (int f = 1; f <= 17; f++) begin
      pulse(3, 2, 2, (f % 2) == 0, f % 16);
    end
    repeat (4) @(negedge clk);
    chk("wrap_fc_final", get_fc(3), 1);

    repeat (10) @(negedge clk);
    chk("pending_strobes", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_frame_counter

// File: doc/frame_counter.md
# frame_counter

Frame-rate divider for the camera tracking path. Detects the start of each video frame from the camera vertical-sync signal and emits a one-cycle `frame_enable` strobe once every `FRAME_DIV` frames. Downstream tracking and DMX update logic use the strobe to process a decimated frame stream. A running frame index is also provided.

## Interface
- `FRAME_DIV`, default 2: number of detected frames per `frame_enable` strobe. Legal values are 1 to 2^`DIV_W`−1.
- `DIV_W`, default 8: width of the internal divide counter.
- `CNT_W`, default 16: width of `frame_count`.
- `VSYNC_ACTIVE_LOW`, default 0: when 1, the frame start is the falling edge of `vsync_in`; when 0, it is the rising edge.

Ports:
- `clk` in 1: the single system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset. The block is held in reset while `reset`=0.
- `vsync_in` in 1: camera vertical sync, raw level.
- `frame_enable` out 1: registered, one-cycle strobe every `FRAME_DIV`-th frame start.
- `frame_count` out `CNT_W`: registered count of all detected frame starts. It wraps modulo 2^`CNT_W`.

## Operation
- Input conditioning:
  - `vs` is `vsync_in`, inverted when `VSYNC_ACTIVE_LOW`=1, then synchronized per Configuration.
  - `vs_prev` is `vs` delayed by one register.
  - `frame_start = vs & ~vs_prev`.
- Divide counter `div_cnt` (`DIV_W` bits):
  - On `frame_start` with `div_cnt == FRAME_DIV-1`: `div_cnt` goes to 0 and `frame_enable` goes to 1 for the next cycle.
  - On `frame_start` otherwise: `div_cnt` increments and `frame_enable` goes to 0.
  - With no `frame_start`: `div_cnt` holds and `frame_enable` goes to 0.
- `frame_count` increments on every `frame_start`.
- `FRAME_DIV`=1: the strobe fires on every frame start.
- Reset (`reset`=0 sampled at a `clk` edge):
  - `div_cnt`=0, `frame_count`=0, `frame_enable`=0.
  - Synchronizer flops=1 and `vs_prev`=1. This value is the active level after polarity inversion.
  - Consequence: a `vsync_in` already active when reset releases is not counted. The first counted frame needs an inactive sample followed by an active one.
- Reset mid-operation discards the partial count. No strobe is produced in any cycle where reset is sampled low.
- Illegal `FRAME_DIV` (0 or too wide for `DIV_W`) is rejected at elaboration.

## Timing
- Without the synchronizer: `vs` at its active level is first sampled at edge k; `frame_enable` is high during cycle k+1, i.e. after edge k+1 (2-cycle latency from the input transition).
- With the synchronizer: latency is 2 cycles greater.
- `frame_enable` is high for exactly one `clk` cycle per strobe.
- `frame_count` updates on the same edge that would raise `frame_enable`.
- Minimum `vsync_in` high and low time for guaranteed detection: 1 `clk` period without the synchronizer, 2 periods with it.
- Back-to-back frame starts are legal. The shortest possible interval is every other cycle.
- Every frame start is counted; none are dropped.

## Configuration
- `FRAME_COUNTER_SYNC_EN`:
  - Defined: `vsync_in` passes through a two-flop synchronizer before edge detection. Use this when the camera is asynchronous to `clk`.
  - Undefined: `vsync_in` is sampled directly into `vs_prev`, and edge detection uses the live input.

## Structure
- Package `frame_counter_pkg`: default constants `FRAME_DIV_DEFAULT`, `DIV_W_DEFAULT`, `CNT_W_DEFAULT`.
- Sub-module `vsync_edge_detect`:
  - Contains the polarity inversion, the optional synchronizer and the one-cycle rising-edge pulse.
  - Ports: `clk`, `reset`, `vsync_in`, `frame_start`.
- The top level holds the divide counter, the strobe register and `frame_count`.

## Test plan
- Reset held: `reset`=0 throughout, `vsync_in` toggling every half clock period → `frame_enable`=0 and `frame_count`=0 at all times.
- Divide by 2: `FRAME_DIV`=2, `reset`=1, 6 vsync pulses each 4 cycles high and 4 cycles low → 3 strobes, on frame starts 2, 4 and 6; `frame_count`=6; each strobe exactly 1 cycle; latency as specified.
- Divide by 1 with active-low vsync: `FRAME_DIV`=1, `VSYNC_ACTIVE_LOW`=1, 3 falling edges → 3 strobes; rising edges produce nothing.
- Active at reset release: `vsync_in` high while reset releases, then low, then high → no strobe or count at release; the later rising edge counts as frame 1.
- Reset mid-count: `FRAME_DIV`=3, reset pulsed low for 1 cycle after 2 frames → `frame_count`=0; the next strobe comes only after 3 further frames.
- Wrap: `CNT_W`=4, 17 frames → `frame_count`=1.
